// File: rtl/serial_to_parallel.sv
// SSP receive deserializer: frame-pulse aligned, MSB-first, N-bit words into a
// single holding register with valid/ready handshake, overrun and framing flags.
module serial_to_parallel #(
    parameter int N = 8
) (
    input  logic         SSPCLKIN,
    input  logic         CLEAR,
    input  logic         SSPRXD,
    input  logic         SSPFSSIN,
    input  logic         rx_ready,
    input  logic         clr_overrun,
    output logic [N-1:0] RxData,
    output logic         rx_valid,
    output logic         overrun,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    // Only the first N-1 bits need storing; the LSB is taken straight from the line.
    logic [N-2:0]  shift;
    logic [N-1:0]  word;
    logic          word_done;
    logic          mid_pulse;
    logic          load_word;
    logic          drop_word;
    logic          read;

    always_comb begin
        word      = {shift, SSPRXD};
        word_done = (state == RECV) && (cnt == '0);
        mid_pulse = (state == RECV) && (cnt != '0) && SSPFSSIN;
        read      = rx_valid && rx_ready;
        load_word = word_done && (!rx_valid || rx_ready);
        drop_word = word_done && rx_valid && !rx_ready;
    end

    always_ff @(posedge SSPCLKIN) begin
        if (CLEAR) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            RxData    <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= mid_pulse;

            case (state)
                IDLE: begin
                    if (SSPFSSIN) begin
                        state <= RECV;
                        cnt   <= CNT_TOP;
                    end
                end
                default: begin
                    shift <= word[N-2:0];
                    if (word_done) begin
                        if (SSPFSSIN) cnt <= CNT_TOP;
                        else          state <= IDLE;
                    end else if (SSPFSSIN) begin
                        cnt <= CNT_TOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase

            if (load_word) begin
                RxData   <= word;
                rx_valid <= 1'b1;
            end else if (read) begin
                rx_valid <= 1'b0;
            end

            // A drop on the same edge as a clear request leaves the flag set.
            if (drop_word)        overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (N=8): expected words are queued as
// frames are sent and checked by a monitor whenever a new word is presented.
module tb_serial_to_parallel;

    logic       clk;
    logic       clear;
    logic       rxd;
    logic       fss;
    logic       rx_ready;
    logic       clr_overrun;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    bit         busy_gap;
    logic       pre_valid;

    serial_to_parallel #(.N(8)) dut (
        .SSPCLKIN    (clk),
        .CLEAR       (clear),
        .SSPRXD      (rxd),
        .SSPFSSIN    (fss),
        .rx_ready    (rx_ready),
        .clr_overrun (clr_overrun),
        .RxData      (rx_data),
        .rx_valid    (rx_valid),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a word is newly presented when rx_valid is high now and the
    // previous cycle either had no valid word or completed a read.
    logic mon_prev_valid = 1'b0;
    logic mon_prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!clear && rx_valid && (!mon_prev_valid || mon_prev_ready)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", rx_data, e);
                end
            end
        end
        mon_prev_valid = rx_valid;
        mon_prev_ready = rx_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input bit chained, input bit chain_next,
                             input bit ready_first, input bit ready_last);
        if (!chained) begin
            fss = 1'b1;
            tick();
            fss = 1'b0;
        end
        for (int i = 7; i >= 0; i--) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            rxd      = w[i];
            rx_ready = (i == 7 && ready_first) || (i == 0 && ready_last);
            fss      = (i == 0 && chain_next);
            if (i == 0) pre_valid = rx_valid;
            tick();
        end
        fss      = 1'b0;
        rx_ready = 1'b0;
        rxd      = 1'b0;
    endtask

    task automatic read_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        clear = 1'b1; rxd = 1'b0; fss = 1'b0; rx_ready = 1'b0; clr_overrun = 1'b0;
        busy_gap = 1'b0;
        tick();
        tick();
        check("reset_rxdata", rx_data, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_overrun", overrun, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        clear = 1'b0;
        tick();

        // Single word, not read
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 0, 0, 0, 0);
        check("a5_valid_before_lsb", pre_valid, 0);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_busy_after", busy, 0);
        check("a5_overrun", overrun, 0);
        check("a5_frame_err", frame_err, 0);
        read_one();
        check("a5_read_clears_valid", rx_valid, 0);

        // Back-to-back frames, second pulse on first frame's LSB edge
        busy_gap = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_word(8'h3C, 0, 1, 0, 0);
        check("b2b_busy_held", busy, 1);
        send_word(8'hC3, 1, 0, 1, 0);
        check("b2b_no_gap", busy_gap, 0);
        check("b2b_data", rx_data, 8'hC3);
        check("b2b_valid", rx_valid, 1);
        check("b2b_overrun", overrun, 0);
        read_one();

        // Overrun: second word dropped while first is pending
        exp_q.push_back(8'h11);
        send_word(8'h11, 0, 0, 0, 0);
        send_word(8'h22, 0, 0, 0, 0);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", rx_valid, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);
        read_one();
        check("ovr_read_valid", rx_valid, 0);

        // Read on the LSB edge of the next word
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h11, 0, 0, 0, 0);
        send_word(8'h22, 0, 0, 0, 1);
        check("swap_data", rx_data, 8'h22);
        check("swap_valid", rx_valid, 1);
        check("swap_overrun", overrun, 0);
        read_one();

        // Mid-word frame pulse restarts the frame
        fss = 1'b1;
        tick();
        fss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            tick();
        end
        rxd = 1'b0;
        fss = 1'b1;
        tick();
        fss = 1'b0;
        check("ferr_pulse", frame_err, 1);
        check("ferr_busy", busy, 1);
        check("ferr_no_delivery", rx_valid, 0);
        exp_q.push_back(8'h5A);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h5A;
            rxd = v[i];
            tick();
            if (i == 7) check("ferr_one_cycle", frame_err, 0);
        end
        rxd = 1'b0;
        check("ferr_data", rx_data, 8'h5A);
        check("ferr_valid", rx_valid, 1);

        // CLEAR mid-frame with a pending word, pulse during CLEAR ignored
        fss = 1'b1;
        tick();
        fss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            tick();
        end
        clear = 1'b1;
        rxd = 1'b0;
        tick();
        check("clr_rxdata", rx_data, 0);
        check("clr_valid", rx_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_overrun", overrun, 0);
        check("clr_frame_err", frame_err, 0);
        fss = 1'b1;
        tick();
        fss = 1'b0;
        clear = 1'b0;
        check("clr_fss_ignored", busy, 0);
        tick();
        exp_q.push_back(8'hF0);
        send_word(8'hF0, 0, 0, 0, 0);
        check("clr_after_data", rx_data, 8'hF0);
        check("clr_after_valid", rx_valid, 1);
        read_one();
        tick();
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
